// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction-fetch stage with skid buffer and redirect discard
//
// Purpose: fetches the instruction at pc_cur over a req/ack handshake, fills the
// IF/ID register with {valid, instr, pc, pc+4} and returns the next PC.
// Optional feature macro: FETCH_PERF_EN (adds perf_fetched / perf_stall counters).
//
// Ports:
//   clk, reset                    clock and synchronous active-high reset
//   pc_cur / pc_next              PC register interface (pc_next is combinational)
//   imem_req/addr/ack/rdata       instruction memory handshake
//   stall                         hold IF/ID contents
//   redirect / redirect_pc        flush and refetch from redirect_pc
//   ifid_valid/instr/pc/pc4       IF/ID pipeline register
//   perf_fetched / perf_stall     counters, present only with FETCH_PERF_EN
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] pend_addr_q, pend_addr_d;

  // One-hot intents for the IF/ID register, resolved after the FSM decode.
  logic        load_en;
  logic [31:0] load_instr;
  logic [31:0] load_pc;
  logic        flush_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FETCH;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= 32'h0;
      ifid_pc4_q   <= 32'h0;
      skid_instr_q <= 32'h0;
      skid_pc_q    <= 32'h0;
      pend_addr_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      pend_addr_q  <= pend_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    pend_addr_d  = pend_addr_q;
    imem_req     = 1'b0;
    imem_addr    = pc_cur;
    pc_next      = pc_cur;
    load_en      = 1'b0;
    load_instr   = imem_rdata;
    load_pc      = pc_cur;
    flush_en     = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          flush_en = 1'b1;
          pc_next  = redirect_pc;
          if (!imem_ack) begin
            // The request already on the bus must still be answered; remember
            // its address so the handshake stays stable until the ack.
            pend_addr_d = pc_cur;
            state_d     = S_DISCARD;
          end
        end else if (imem_ack) begin
          if (stall) begin
            skid_instr_d = imem_rdata;
            skid_pc_d    = pc_cur;
            state_d      = S_HOLD;
          end else begin
            load_en = 1'b1;
            pc_next = pc_cur + 32'd4;
          end
        end else if (!stall) begin
          flush_en = 1'b1;  // bubble while waiting on memory
        end
      end

      S_HOLD: begin
        if (redirect) begin
          flush_en     = 1'b1;
          skid_instr_d = 32'h0;
          skid_pc_d    = 32'h0;
          pc_next      = redirect_pc;
          state_d      = S_FETCH;
        end else if (!stall) begin
          load_en      = 1'b1;
          load_instr   = skid_instr_q;
          load_pc      = skid_pc_q;
          skid_instr_d = 32'h0;
          skid_pc_d    = 32'h0;
          pc_next      = pc_cur + 32'd4;
          state_d      = S_FETCH;
        end
      end

      S_DISCARD: begin
        imem_req  = 1'b1;
        imem_addr = pend_addr_q;
        if (redirect) begin
          flush_en = 1'b1;
          pc_next  = redirect_pc;
        end
        if (imem_ack) begin
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase

    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    if (load_en) begin
      ifid_valid_d = 1'b1;
      ifid_instr_d = load_instr;
      ifid_pc_d    = load_pc;
      ifid_pc4_d   = load_pc + 32'd4;
    end else if (flush_en) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
    end

    // Reset dominates the combinational outputs as well as the state.
    if (reset) begin
      imem_req = 1'b0;
      pc_next  = RESET_PC;
    end
  end

  assign ifid_valid = ifid_valid_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_pc4   = ifid_pc4_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= 32'h0;
      perf_stall_q   <= 32'h0;
    end else begin
      if (load_en) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if (stall && ifid_valid_q) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_cur;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } sb_entry_t;

  sb_entry_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC (RST_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_cur     (pc_cur),
    .pc_next    (pc_next),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .ifid_valid (ifid_valid),
    .ifid_instr (ifid_instr),
    .ifid_pc    (ifid_pc),
    .ifid_pc4   (ifid_pc4)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stall  (perf_stall)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of stimulus. Combinational outputs are checked mid-cycle, the
  // IF/ID register just after the edge; push queues the instruction this cycle
  // captures, pop compares the entry expected to land in IF/ID at this edge.
  task automatic step(input logic rst, input logic [31:0] pc, input logic ack,
                      input logic [31:0] rd, input logic stl, input logic rdr,
                      input logic [31:0] rpc, input logic [31:0] exp_next,
                      input logic exp_req, input logic [31:0] exp_addr,
                      input logic exp_valid, input logic push, input logic pop);
    sb_entry_t e;
    @(negedge clk);
    reset = rst; pc_cur = pc; imem_ack = ack; imem_rdata = rd;
    stall = stl; redirect = rdr; redirect_pc = rpc;
    #1;
    check("pc_next", pc_next, exp_next);
    check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) check("imem_addr", imem_addr, exp_addr);
    if (push) begin
      e.instr = rd;
      e.pc    = pc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    check("ifid_valid", {31'b0, ifid_valid}, {31'b0, exp_valid});
    if (!exp_valid) check("ifid_instr_nop", ifid_instr, NOP);
    if (pop) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("sb_instr", ifid_instr, e.instr);
        check("sb_pc", ifid_pc, e.pc);
        check("sb_pc4", ifid_pc4, e.pc + 32'd4);
      end
    end
  endtask

  initial begin
    reset = 1'b1; pc_cur = '0; imem_ack = 1'b0; imem_rdata = '0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

    // reset
    step(1, 32'h0, 0, 32'h0, 0, 0, 32'h0, RST_PC, 0, 32'h0, 0, 0, 0);
    step(1, 32'h0, 1, 32'h5, 0, 0, 32'h0, RST_PC, 0, 32'h0, 0, 0, 0);
    check("rst_ifid_pc", ifid_pc, 32'h0);
    check("rst_ifid_pc4", ifid_pc4, 32'h0);
`ifdef FETCH_PERF_EN
    check("rst_perf_fetched", perf_fetched, 32'h0);
    check("rst_perf_stall", perf_stall, 32'h0);
`endif

    // zero-wait back-to-back fetch
    step(0, 32'h0, 1, 32'hA000_0000, 0, 0, 32'h0, 32'h4, 1, 32'h0, 1, 1, 1);
    step(0, 32'h4, 1, 32'hA000_0004, 0, 0, 32'h0, 32'h8, 1, 32'h4, 1, 1, 1);
    step(0, 32'h8, 1, 32'hA000_0008, 0, 0, 32'h0, 32'hC, 1, 32'h8, 1, 1, 1);

    // two-cycle ack: bubbles then the instruction
    step(0, 32'h10, 0, 32'h0, 0, 0, 32'h0, 32'h10, 1, 32'h10, 0, 0, 0);
    step(0, 32'h10, 0, 32'h0, 0, 0, 32'h0, 32'h10, 1, 32'h10, 0, 0, 0);
    step(0, 32'h10, 1, 32'hA000_0010, 0, 0, 32'h0, 32'h14, 1, 32'h10, 1, 1, 1);

    // stall with ack -> skid, hold, release
    step(0, 32'h20, 1, 32'hA000_0020, 1, 0, 32'h0, 32'h20, 1, 32'h20, 1, 1, 0);
    check("hold_ifid_pc_a", ifid_pc, 32'h10);
    step(0, 32'h20, 0, 32'h0, 1, 0, 32'h0, 32'h20, 0, 32'h0, 1, 0, 0);
    check("hold_ifid_pc_b", ifid_pc, 32'h10);
    step(0, 32'h20, 0, 32'h0, 0, 0, 32'h0, 32'h24, 0, 32'h0, 1, 0, 1);

    // redirect without ack -> DISCARD keeps the old address until ack
    step(0, 32'h30, 0, 32'h0, 0, 1, 32'h100, 32'h100, 1, 32'h30, 0, 0, 0);
    step(0, 32'h100, 0, 32'h0, 0, 0, 32'h0, 32'h100, 1, 32'h30, 0, 0, 0);
    step(0, 32'h100, 1, 32'hDEAD_BEEF, 0, 0, 32'h0, 32'h100, 1, 32'h30, 0, 0, 0);
    step(0, 32'h100, 1, 32'hA000_0100, 0, 0, 32'h0, 32'h104, 1, 32'h100, 1, 1, 1);

    // redirect with ack in FETCH: data dropped
    step(0, 32'h104, 1, 32'hDEAD_0104, 0, 1, 32'h200, 32'h200, 1, 32'h104, 0, 0, 0);
    step(0, 32'h200, 1, 32'hA000_0200, 0, 0, 32'h0, 32'h204, 1, 32'h200, 1, 1, 1);

    // redirect and stall together in HOLD: skid discarded
    step(0, 32'h204, 1, 32'hDEAD_0204, 1, 0, 32'h0, 32'h204, 1, 32'h204, 1, 0, 0);
    step(0, 32'h204, 0, 32'h0, 1, 1, 32'h300, 32'h300, 0, 32'h0, 0, 0, 0);
    step(0, 32'h300, 1, 32'hA000_0300, 0, 0, 32'h0, 32'h304, 1, 32'h300, 1, 1, 1);

    // pc+4 wrap
    step(0, 32'hFFFF_FFFC, 1, 32'hA000_FFFC, 0, 0, 32'h0, 32'h0, 1, 32'hFFFF_FFFC, 1, 1, 1);

    // stall without ack in FETCH: IF/ID holds
    step(0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 32'h0, 1, 32'h0, 1, 0, 0);
    check("stall_noack_pc", ifid_pc, 32'hFFFF_FFFC);

    // reset in the middle of DISCARD
    step(0, 32'h40, 0, 32'h0, 0, 1, 32'h500, 32'h500, 1, 32'h40, 0, 0, 0);
    step(1, 32'h500, 0, 32'h0, 0, 0, 32'h0, RST_PC, 0, 32'h0, 0, 0, 0);
`ifdef FETCH_PERF_EN
    check("rst2_perf_fetched", perf_fetched, 32'h0);
    check("rst2_perf_stall", perf_stall, 32'h0);
`endif
    step(0, 32'h80, 1, 32'hA000_0080, 0, 0, 32'h0, 32'h84, 1, 32'h80, 1, 1, 1);

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
